// File: rtl/alu_pkg.sv
// Shared encodings for the ALU decoder and multiply/divide unit.
package alu_pkg;

  typedef enum logic [3:0] {
    AC_AND  = 4'b0000,
    AC_OR   = 4'b0001,
    AC_ADD  = 4'b0010,
    AC_XOR  = 4'b0011,
    AC_NOR  = 4'b0100,
    AC_SUB  = 4'b0110,
    AC_SLT  = 4'b0111,
    AC_SLTU = 4'b1000,
    AC_ILL  = 4'b1111
  } alucontrol_t;

  typedef enum logic [5:0] {
    F_MFHI  = 6'b010000,
    F_MFLO  = 6'b010010,
    F_MULT  = 6'b011000,
    F_MULTU = 6'b011001,
    F_DIV   = 6'b011010,
    F_DIVU  = 6'b011011,
    F_ADD   = 6'b100000,
    F_ADDU  = 6'b100001,
    F_SUB   = 6'b100010,
    F_SUBU  = 6'b100011,
    F_AND   = 6'b100100,
    F_OR    = 6'b100101,
    F_XOR   = 6'b100110,
    F_NOR   = 6'b100111,
    F_SLT   = 6'b101010,
    F_SLTU  = 6'b101011
  } funct_t;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_OR    = 2'b11;

  typedef enum logic [1:0] {MUL, MULU, DIV, DIVU} md_op_t;

  function automatic logic is_md_op(input logic [5:0] f);
    return (f == F_MULT) || (f == F_MULTU) || (f == F_DIV) || (f == F_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_core.sv
// Iterative multiply/divide engine: one radix-2 step per cycle, sign fix-up, HI/LO registers.
module muldiv_core
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  md_op_t           op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t             state;
  logic [CW-1:0]      cnt;
  md_op_t             cur_op;
  logic [WIDTH-1:0]   mb;
  logic [2*WIDTH-1:0] p;
  logic               sign_x;
  logic               sign_a;
  logic               divzero;
  logic [WIDTH-1:0]   a_raw;

  logic               is_signed;
  logic               sa;
  logic               sb;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic               is_mul;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic [2*WIDTH-1:0] div_next;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  always_comb begin
    is_signed = (op == MUL) || (op == DIV);
    sa        = is_signed & a[WIDTH-1];
    sb        = is_signed & b[WIDTH-1];
    a_mag     = sa ? -a : a;
    b_mag     = sb ? -b : b;
  end

  // p holds {accumulator/remainder, multiplier/quotient}; both ops shift through the low half
  always_comb begin
    is_mul    = (cur_op == MUL) || (cur_op == MULU);
    mul_sum   = {1'b0, p[2*WIDTH-1:WIDTH]} + (p[0] ? {1'b0, mb} : '0);
    mul_next  = {mul_sum, p[WIDTH-1:1]};
    div_shift = p[2*WIDTH-1:WIDTH-1];
    div_diff  = div_shift - {1'b0, mb};
    div_next  = div_diff[WIDTH] ? {div_shift[WIDTH-1:0], p[WIDTH-2:0], 1'b0}
                                : {div_diff[WIDTH-1:0], p[WIDTH-2:0], 1'b1};
    prod_fix  = sign_x ? -p : p;
    quo_fix   = divzero ? '1 : (sign_x ? -p[WIDTH-1:0] : p[WIDTH-1:0]);
    rem_fix   = divzero ? a_raw : (sign_a ? -p[2*WIDTH-1:WIDTH] : p[2*WIDTH-1:WIDTH]);
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      cur_op  <= MUL;
      mb      <= '0;
      p       <= '0;
      sign_x  <= 1'b0;
      sign_a  <= 1'b0;
      divzero <= 1'b0;
      a_raw   <= '0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state   <= RUN;
            cnt     <= '0;
            cur_op  <= op;
            mb      <= b_mag;
            p       <= {{WIDTH{1'b0}}, a_mag};
            sign_x  <= sa ^ sb;
            sign_a  <= sa;
            divzero <= (b == '0);
            a_raw   <= a;
          end
        end
        RUN: begin
          p <= is_mul ? mul_next : div_next;
          if (cnt == CW'(WIDTH - 1)) state <= FIX;
          else                       cnt   <= cnt + 1'b1;
        end
        FIX: begin
          if (is_mul) begin
            hi <= prod_fix[2*WIDTH-1:WIDTH];
            lo <= prod_fix[WIDTH-1:0];
          end else begin
            hi <= rem_fix;
            lo <= quo_fix;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/aludec_md.sv
// MIPS ALU decoder with attached multiply/divide unit, pipeline stall and mfhi/mflo read-out.
module aludec_md
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       aluop,
  input  logic [5:0]       funct,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [3:0]       alucontrol,
  output logic             illegal,
  output logic             md_sel,
  output logic [WIDTH-1:0] md_result,
  output logic             busy,
  output logic             stall,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  alucontrol_t ac;
  md_op_t      md_op;
  logic        rtype;
  logic        md_fn;
  logic        is_mfhi;
  logic        is_mflo;
  logic        md_go;

  always_comb begin
    ac      = AC_ADD;
    illegal = 1'b0;
    case (aluop)
      ALUOP_ADD: ac = AC_ADD;
      ALUOP_SUB: ac = AC_SUB;
      ALUOP_OR:  ac = AC_OR;
      default: begin
        case (funct)
          F_ADD, F_ADDU: ac = AC_ADD;
          F_SUB, F_SUBU: ac = AC_SUB;
          F_AND:         ac = AC_AND;
          F_OR:          ac = AC_OR;
          F_XOR:         ac = AC_XOR;
          F_NOR:         ac = AC_NOR;
          F_SLT:         ac = AC_SLT;
          F_SLTU:        ac = AC_SLTU;
          F_MULT, F_MULTU, F_DIV, F_DIVU, F_MFHI, F_MFLO: ac = AC_ADD;
          default: begin
            ac      = AC_ILL;
            illegal = 1'b1;
          end
        endcase
      end
    endcase
  end

  assign alucontrol = ac;

  always_comb begin
    md_op = MUL;
    case (funct)
      F_MULTU: md_op = MULU;
      F_DIV:   md_op = DIV;
      F_DIVU:  md_op = DIVU;
      default: md_op = MUL;
    endcase
  end

  assign rtype   = (aluop == ALUOP_RTYPE);
  assign md_fn   = is_md_op(funct);
  assign is_mfhi = rtype && (funct == F_MFHI);
  assign is_mflo = rtype && (funct == F_MFLO);
  assign md_go   = start && rtype && md_fn;
  assign stall   = start && busy && rtype && (md_fn || (funct == F_MFHI) || (funct == F_MFLO));

  assign md_sel    = is_mfhi || is_mflo;
  assign md_result = is_mfhi ? hi : (is_mflo ? lo : '0);

  muldiv_core #(.WIDTH(WIDTH)) u_core (
    .clk   (clk),
    .reset (reset),
    .start (md_go),
    .op    (md_op),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .hi    (hi),
    .lo    (lo)
  );

endmodule

// File: tb/tb_aludec_md.sv
// Bench for aludec_md: decode sweep, directed mul/div corner cases, stall/mflo, reset, random ops.
module tb_aludec_md;

  localparam int unsigned W = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    aluop;
  logic [5:0]    funct;
  logic          start;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic [3:0]    alucontrol;
  logic          illegal;
  logic          md_sel;
  logic [W-1:0]  md_result;
  logic          busy;
  logic          stall;
  logic [W-1:0]  hi;
  logic [W-1:0]  lo;

  int nchk  = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  aludec_md #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .aluop      (aluop),
    .funct      (funct),
    .start      (start),
    .a          (a),
    .b          (b),
    .alucontrol (alucontrol),
    .illegal    (illegal),
    .md_sel     (md_sel),
    .md_result  (md_result),
    .busy       (busy),
    .stall      (stall),
    .hi         (hi),
    .lo         (lo)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: 64-bit integer arithmetic on the architectural operands
  function automatic void model(input logic [5:0] f, input logic [31:0] x, input logic [31:0] y,
                                output logic [31:0] eh, output logic [31:0] el);
    longint     sx, sy, q, r;
    logic [63:0] pr;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    pr = '0;
    case (f)
      6'b011000: pr = sx * sy;
      6'b011001: pr = {32'b0, x} * {32'b0, y};
      6'b011010: begin
        if (y == 0) pr = {x, 32'hFFFF_FFFF};
        else begin
          q  = sx / sy;
          r  = sx % sy;
          pr = {r[31:0], q[31:0]};
        end
      end
      6'b011011: begin
        if (y == 0) pr = {x, 32'hFFFF_FFFF};
        else        pr = {x % y, x / y};
      end
      default: pr = '0;
    endcase
    eh = pr[63:32];
    el = pr[31:0];
  endfunction

  task automatic run_op(input string tag, input logic [5:0] f, input logic [31:0] x, input logic [31:0] y);
    logic [31:0] eh, el;
    int n;
    model(f, x, y, eh, el);
    @(negedge clk);
    aluop = 2'b10; funct = f; start = 1'b1; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0; funct = 6'b100000;
    n = 0;
    while (busy && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, " latency"}, n, W + 1);
    check({tag, " hi"}, hi, eh);
    check({tag, " lo"}, lo, el);
  endtask

  task automatic dec(input logic [1:0] op, input logic [5:0] f, input logic [3:0] ac, input logic il);
    @(negedge clk);
    aluop = op; funct = f; start = 1'b0;
    #1;
    check($sformatf("dec %b/%b ac", op, f), {28'b0, alucontrol}, {28'b0, ac});
    check($sformatf("dec %b/%b ill", op, f), {31'b0, illegal}, {31'b0, il});
  endtask

  logic [5:0] dfun [17] = '{6'b100000, 6'b100001, 6'b100010, 6'b100011, 6'b100100, 6'b100101,
                            6'b100110, 6'b100111, 6'b101010, 6'b101011, 6'b011000, 6'b011001,
                            6'b011010, 6'b011011, 6'b010000, 6'b010010, 6'b000001};
  logic [3:0] dexp [17] = '{4'b0010, 4'b0010, 4'b0110, 4'b0110, 4'b0000, 4'b0001,
                            4'b0011, 4'b0100, 4'b0111, 4'b1000, 4'b0010, 4'b0010,
                            4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b1111};

  initial begin
    int n;
    logic [5:0]  rf;
    logic [31:0] rx, ry;

    reset = 1'b1; aluop = 2'b00; funct = 6'b0; start = 1'b0; a = '0; b = '0;
    @(negedge clk); #1;
    check("reset busy", {31'b0, busy}, 32'd0);
    check("reset stall", {31'b0, stall}, 32'd0);
    check("reset hi", hi, 32'd0);
    check("reset lo", lo, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 17; i++) dec(2'b10, dfun[i], dexp[i], (i == 16) ? 1'b1 : 1'b0);
    dec(2'b00, 6'b000001, 4'b0010, 1'b0);
    dec(2'b01, 6'b100100, 4'b0110, 1'b0);
    dec(2'b11, 6'b100100, 4'b0001, 1'b0);

    run_op("mult -3x7", 6'b011000, 32'hFFFF_FFFD, 32'd7);
    @(negedge clk);
    aluop = 2'b10; funct = 6'b010000; start = 1'b0; #1;
    check("mfhi sel", {31'b0, md_sel}, 32'd1);
    check("mfhi result", md_result, 32'hFFFF_FFFF);
    funct = 6'b100000; #1;
    check("add sel", {31'b0, md_sel}, 32'd0);
    check("add result", md_result, 32'd0);

    run_op("div -7/2", 6'b011010, 32'hFFFF_FFF9, 32'd2);
    run_op("divu 7/0", 6'b011011, 32'd7, 32'd0);
    run_op("div -5/0", 6'b011010, 32'hFFFF_FFFB, 32'd0);
    run_op("div min/-1", 6'b011010, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("multu max", 6'b011001, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op("mult minxmin", 6'b011000, 32'h8000_0000, 32'h8000_0000);
    run_op("divu big", 6'b011011, 32'hFFFF_FFFF, 32'd10);

    // MFLO one cycle behind MULT 5x6, with an ADD slipped in mid-operation
    @(negedge clk);
    aluop = 2'b10; funct = 6'b011000; start = 1'b1; a = 32'd5; b = 32'd6;
    @(posedge clk); #1;
    funct = 6'b100000;
    #1;
    check("add while busy stall", {31'b0, stall}, 32'd0);
    @(negedge clk);
    funct = 6'b010010; #1;
    check("mflo stall", {31'b0, stall}, 32'd1);
    n = 0;
    while (busy && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("mflo busy drop", {31'b0, busy}, 32'd0);
    check("mflo stall released", {31'b0, stall}, 32'd0);
    check("mflo result", md_result, 32'h0000_001E);
    @(negedge clk);
    start = 1'b0; funct = 6'b100000;

    // Asynchronous reset during iteration 10 of a DIV, with a held MULT stalled behind it
    @(negedge clk);
    aluop = 2'b10; funct = 6'b011010; start = 1'b1; a = 32'd1000; b = 32'd7;
    @(posedge clk); #1;
    funct = 6'b011000;
    repeat (10) @(posedge clk);
    #2;
    check("pre-reset stall", {31'b0, stall}, 32'd1);
    reset = 1'b1; #1;
    check("mid reset busy", {31'b0, busy}, 32'd0);
    check("mid reset stall", {31'b0, stall}, 32'd0);
    check("mid reset hi", hi, 32'd0);
    check("mid reset lo", lo, 32'd0);
    start = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    run_op("mult 2x3", 6'b011000, 32'd2, 32'd3);

    for (int i = 0; i < 24; i++) begin
      rf = 6'b011000 + 6'($urandom_range(0, 3));
      rx = $urandom;
      case ($urandom_range(0, 7))
        0:       ry = 32'd0;
        1, 2:    ry = $urandom_range(1, 15);
        3:       ry = 32'hFFFF_FFFF;
        default: ry = $urandom;
      endcase
      run_op($sformatf("rand%0d f=%b a=%h b=%h", i, rf, rx, ry), rf, rx, ry);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
